// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between the RV32I control/datapath
// (master) and the memory responder (slave).
//
// Handshake: the master raises mem_read or mem_write together with
// mem_address, mem_byte_enable and mem_wdata, and holds the request high until
// it sees mem_resp. mem_resp is a single-cycle completion pulse. mem_rdata and
// mem_err are valid in that cycle. Dropping both request lines before mem_resp
// aborts the transaction, and no response follows.
interface mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        mem_err;

  modport master (
    output mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata,
    input  mem_rdata, mem_resp, mem_err
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata,
    output mem_rdata, mem_resp, mem_err
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: single-port 32-bit memory that answers read and write
// requests with a one-cycle mem_resp pulse after LATENCY cycles.
// Optional feature macro: MEM_RESPONDER_RANDOM_STALL_EN adds an 8-bit LFSR
// that inserts 0..3 extra wait cycles per accepted transaction.
// FSM state is exposed on state_dbg (IDLE=0, BUSY=1, RESP=2).
module mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 3
) (
  input  logic             clk,
  input  logic             rst,
  mem_responder_if.slave   bus,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEPTH = 1 << ADDR_WIDTH;

  state_t state;
  state_t next_state;
  logic [4:0] cnt;
  logic [4:0] cnt_next;
  logic [4:0] load_cnt;
  logic [1:0] stall_extra;

  // Transaction fields captured at acceptance.
  logic                  lat_write;
  logic                  lat_err;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [3:0]            lat_be;
  logic [31:0]           lat_wdata;

  // Fields of the transaction being committed; in IDLE these come straight
  // from the bus so a zero-wait transaction can commit on its acceptance edge.
  logic                  cur_write;
  logic                  cur_err;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [3:0]            cur_be;
  logic [31:0]           cur_wdata;

  logic live_req;
  logic live_err;
  logic enter_resp;
  logic commit_write;
  logic unused_addr_bits;

  logic [31:0] mem_array [0:DEPTH-1];

  assign live_req = bus.mem_read | bus.mem_write;
  assign live_err = (bus.mem_read & bus.mem_write) |
                    (|bus.mem_address[31:ADDR_WIDTH+2]);
  assign unused_addr_bits = ^bus.mem_address[1:0];

`ifdef MEM_RESPONDER_RANDOM_STALL_EN
  logic [7:0] lfsr;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, stepped once per accepted transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= 8'hA5;
    end else if (state == IDLE && live_req) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign stall_extra = lfsr[1:0];
`else
  assign stall_extra = 2'b00;
`endif

  assign load_cnt = 5'(LATENCY - 1) + {3'b000, stall_extra};

  assign cur_write = (state == IDLE) ? bus.mem_write : lat_write;
  assign cur_err   = (state == IDLE) ? live_err : lat_err;
  assign cur_addr  = (state == IDLE) ? bus.mem_address[ADDR_WIDTH+1:2] : lat_addr;
  assign cur_be    = (state == IDLE) ? bus.mem_byte_enable : lat_be;
  assign cur_wdata = (state == IDLE) ? bus.mem_wdata : lat_wdata;

  // Next-state and counter logic: accept in IDLE, count down in BUSY, abort
  // when the initiator drops its request, and leave RESP after one cycle.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (live_req) begin
          cnt_next   = load_cnt;
          next_state = (load_cnt == 5'd0) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (!live_req) begin
          cnt_next   = 5'd0;
          next_state = IDLE;
        end else if (cnt <= 5'd1) begin
          cnt_next   = 5'd0;
          next_state = RESP;
        end else begin
          cnt_next = cnt - 5'd1;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        cnt_next   = 5'd0;
        next_state = IDLE;
      end
    endcase
  end

  assign enter_resp   = (next_state == RESP) && (state != RESP);
  assign commit_write = enter_resp && rst && !cur_err && cur_write;

  // State, counter, captured request fields and the registered read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_addr  <= '0;
      lat_be    <= 4'h0;
      lat_wdata <= 32'h0;
      bus.mem_rdata <= 32'h0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      if (state == IDLE && live_req) begin
        lat_write <= bus.mem_write;
        lat_err   <= live_err;
        lat_addr  <= bus.mem_address[ADDR_WIDTH+1:2];
        lat_be    <= bus.mem_byte_enable;
        lat_wdata <= bus.mem_wdata;
      end
      if (enter_resp) begin
        if (cur_err) begin
          bus.mem_rdata <= 32'h0;
        end else if (!cur_write) begin
          bus.mem_rdata <= mem_array[cur_addr];
        end
      end
    end
  end

  // Byte-lane write into the unreset array on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (commit_write) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be[i]) begin
          mem_array[cur_addr][8*i +: 8] <= cur_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.mem_resp = (state == RESP);
  assign bus.mem_err  = (state == RESP) && lat_err;
  assign state_dbg    = state;

endmodule
